// File: rtl/alu_multibyte_seq.sv
// Byte-serial sequencer that drives a shared W-bit combinational ALU for multi-byte ops.
// Optional: define SEQ_ABORT_EN to add the Abort input that cancels a running op.
package alu_multibyte_seq_pkg;

  typedef enum logic [3:0] {
    CLR = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    AND = 4'd3,
    OR  = 4'd4,
    XOR = 4'd5,
    LSH = 4'd6,
    RSH = 4'd7
  } op_mne;

  typedef enum logic [2:0] {
    MADD = 3'd0,
    MSUB = 3'd1,
    MLSH = 3'd2,
    MRSH = 3'd3,
    MXOR = 3'd4,
    MAND = 3'd5,
    MOR  = 3'd6,
    MRSV = 3'd7
  } cmd_e;

endpackage

module alu_multibyte_seq
  import alu_multibyte_seq_pkg::*;
#(
  parameter int unsigned W      = 8,
  parameter int unsigned NBYTES = 4,
  localparam int unsigned LW    = $clog2(NBYTES + 1),
  localparam int unsigned DW    = NBYTES * W
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
`ifdef SEQ_ABORT_EN
  input  logic          Abort,
`endif
  input  logic [2:0]    Cmd,
  input  logic [LW-1:0] Len,
  input  logic [DW-1:0] OpA,
  input  logic [DW-1:0] OpB,
  output logic          Ready,
  output logic          Done,
  output logic          Err,
  output logic [DW-1:0] Result,
  output logic          CarryOut,
  output logic          ZeroOut,
  output logic [W-1:0]  AluA,
  output logic [W-1:0]  AluB,
  output op_mne         AluOP,
  output logic          AluSCin,
  input  logic [W-1:0]  AluOut,
  input  logic          AluSCout
);

  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state, state_d;
  cmd_e   cmd_q, cmd_d;

  logic [NBYTES-1:0][W-1:0] a_q, a_d;
  logic [NBYTES-1:0][W-1:0] b_q, b_d;
  logic [NBYTES-1:0][W-1:0] res_q, res_d;

  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          carry_q, carry_d;
  logic          zacc_q, zacc_d;

  logic          done_d, err_d, cout_d, zout_d;
  logic [W-1:0]  alu_a_d, alu_b_d;
  op_mne         alu_op_d;
  logic          alu_scin_d;

  logic legal, last, is_logic, aborting;

`ifdef SEQ_ABORT_EN
  assign aborting = Abort;
`else
  assign aborting = 1'b0;
`endif

  assign legal    = (Cmd != MRSV) && (Len != '0) && (Len <= LW'(NBYTES));
  assign last     = (rem_q == LW'(1));
  assign is_logic = (cmd_q == MXOR) || (cmd_q == MAND) || (cmd_q == MOR);
  assign Result   = res_q;

  // Next-state, datapath update and the ALU drive for the coming cycle
  always_comb begin
    state_d    = state;
    cmd_d      = cmd_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    idx_d      = idx_q;
    rem_d      = rem_q;
    carry_d    = carry_q;
    zacc_d     = zacc_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cout_d     = CarryOut;
    zout_d     = ZeroOut;
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_op_d   = CLR;
    alu_scin_d = 1'b0;

    case (state)
      IDLE: begin
        if (Start) begin
          if (legal) begin
            state_d = RUN;
            cmd_d   = cmd_e'(Cmd);
            a_d     = OpA;
            b_d     = OpB;
            res_d   = '0;
            rem_d   = Len;
            idx_d   = (Cmd == MRSH) ? IW'(Len - LW'(1)) : '0;
            carry_d = (Cmd == MSUB);
            zacc_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      RUN: begin
        if (aborting) begin
          state_d = IDLE;
          res_d   = '0;
        end else begin
          res_d[idx_q] = AluOut;
          carry_d      = AluSCout;
          zacc_d       = zacc_q & (AluOut == '0);
          rem_d        = rem_q - LW'(1);
          idx_d        = (cmd_q == MRSH) ? idx_q - IW'(1) : idx_q + IW'(1);
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
            cout_d  = is_logic ? 1'b0 : AluSCout;
            zout_d  = zacc_d;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Operands for the byte the ALU will see next cycle; carry seeds the chain
    if (state_d == RUN) begin
      alu_a_d = a_d[idx_d];
      case (cmd_d)
        MADD: begin
          alu_op_d   = ADD;
          alu_b_d    = b_d[idx_d];
          alu_scin_d = carry_d;
        end
        MSUB: begin
          alu_op_d   = ADD;
          alu_b_d    = ~b_d[idx_d];
          alu_scin_d = carry_d;
        end
        MLSH: begin
          alu_op_d   = LSH;
          alu_scin_d = carry_d;
        end
        MRSH: begin
          alu_op_d   = RSH;
          alu_scin_d = carry_d;
        end
        MXOR: begin
          alu_op_d = XOR;
          alu_b_d  = b_d[idx_d];
        end
        MAND: begin
          alu_op_d = AND;
          alu_b_d  = b_d[idx_d];
        end
        MOR: begin
          alu_op_d = OR;
          alu_b_d  = b_d[idx_d];
        end
        default: begin
          alu_op_d = CLR;
          alu_a_d  = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      cmd_q    <= MADD;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      carry_q  <= 1'b0;
      zacc_q   <= 1'b0;
      Ready    <= 1'b1;
      Done     <= 1'b0;
      Err      <= 1'b0;
      CarryOut <= 1'b0;
      ZeroOut  <= 1'b0;
      AluA     <= '0;
      AluB     <= '0;
      AluOP    <= CLR;
      AluSCin  <= 1'b0;
    end else begin
      state    <= state_d;
      cmd_q    <= cmd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      zacc_q   <= zacc_d;
      Ready    <= (state_d == IDLE);
      Done     <= done_d;
      Err      <= err_d;
      CarryOut <= cout_d;
      ZeroOut  <= zout_d;
      AluA     <= alu_a_d;
      AluB     <= alu_b_d;
      AluOP    <= alu_op_d;
      AluSCin  <= alu_scin_d;
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Self-checking bench for alu_multibyte_seq with a behavioural 8-bit ALU attached.
// Abort scenario is exercised only when SEQ_ABORT_EN is defined.
module tb_alu_multibyte_seq;
  import alu_multibyte_seq_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned NB = 4;
  localparam int unsigned LW = $clog2(NB + 1);
  localparam int unsigned DW = NB * W;

  logic          clk;
  logic          reset_n;
  logic          start;
`ifdef SEQ_ABORT_EN
  logic          abort;
`endif
  logic [2:0]    cmd;
  logic [LW-1:0] len;
  logic [DW-1:0] op_a, op_b;
  logic          ready, done, err;
  logic [DW-1:0] result;
  logic          carry_out, zero_out;
  logic [W-1:0]  alu_a, alu_b, alu_out;
  op_mne         alu_op;
  logic          alu_scin, alu_sco;
  logic [W:0]    sum;

  typedef struct {
    logic [DW-1:0] res;
    logic          c;
    logic          z;
    logic          e;
  } exp_t;

  exp_t          sbq[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] prev_res;
  logic          prev_c, prev_z;

  alu_multibyte_seq #(.W(W), .NBYTES(NB)) dut (
    .Clk      (clk),
    .Reset_n  (reset_n),
    .Start    (start),
`ifdef SEQ_ABORT_EN
    .Abort    (abort),
`endif
    .Cmd      (cmd),
    .Len      (len),
    .OpA      (op_a),
    .OpB      (op_b),
    .Ready    (ready),
    .Done     (done),
    .Err      (err),
    .Result   (result),
    .CarryOut (carry_out),
    .ZeroOut  (zero_out),
    .AluA     (alu_a),
    .AluB     (alu_b),
    .AluOP    (alu_op),
    .AluSCin  (alu_scin),
    .AluOut   (alu_out),
    .AluSCout (alu_sco)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU the sequencer drives
  always_comb begin
    sum     = '0;
    alu_out = '0;
    alu_sco = 1'b0;
    case (alu_op)
      ADD: begin
        sum     = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_scin};
        alu_out = sum[W-1:0];
        alu_sco = sum[W];
      end
      LSH: begin
        alu_out = {alu_a[W-2:0], alu_scin};
        alu_sco = alu_a[W-1];
      end
      RSH: begin
        alu_out = {alu_scin, alu_a[W-1:1]};
        alu_sco = alu_a[0];
      end
      AND:     alu_out = alu_a & alu_b;
      OR:      alu_out = alu_a | alu_b;
      XOR:     alu_out = alu_a ^ alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference for a legal op
  function automatic exp_t model(input logic [2:0] c, input int n,
                                 input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [63:0] m, aa, bb, s;
    exp_t r;
    m  = (64'd1 << (n * 8)) - 64'd1;
    aa = 64'(a) & m;
    bb = 64'(b) & m;
    r.c = 1'b0;
    r.e = 1'b0;
    case (c)
      3'd0: begin s = aa + bb;                 r.c = s[n*8];     end
      3'd1: begin s = aa + (~bb & m) + 64'd1;  r.c = s[n*8];     end
      3'd2: begin s = aa << 1;                 r.c = aa[n*8-1];  end
      3'd3: begin s = aa >> 1;                 r.c = aa[0];      end
      3'd4: s = aa ^ bb;
      3'd5: s = aa & bb;
      3'd6: s = aa | bb;
      default: s = '0;
    endcase
    r.res = DW'(s & m);
    r.z   = ((s & m) == 64'd0);
    return r;
  endfunction

  // Issue one op, optionally hammering Start while busy, then score the Done beat
  task automatic run_op(input logic [2:0] c, input int n, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input bit spam);
    exp_t e, got;
    int   lat, exp_lat;
    bit   ok;
    ok = (c != 3'd7) && (n >= 1) && (n <= int'(NB));
    @(negedge clk);
    check("ready_idle", 64'(ready), 64'd1);
    check("aluop_idle", 64'(alu_op), 64'(CLR));
    start = 1'b1;
    cmd   = c;
    len   = LW'(n);
    op_a  = a;
    op_b  = b;
    if (ok) e = model(c, n, a, b);
    else begin
      e.res = prev_res;
      e.c   = prev_c;
      e.z   = prev_z;
      e.e   = 1'b1;
    end
    sbq.push_back(e);
    exp_lat = ok ? n + 1 : 1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (spam && k <= n) begin
        start = 1'b1;
        cmd   = 3'($urandom_range(0, 7));
        len   = LW'($urandom_range(0, 7));
        op_a  = $urandom;
        op_b  = $urandom;
      end else start = 1'b0;
      if (k == 1) check("ready_busy", 64'(ready), 64'd0);
      if (done) begin
        lat = k;
        break;
      end
    end
    check("done_latency", 64'(lat), 64'(exp_lat));
    got = sbq.pop_front();
    check("result", 64'(result), 64'(got.res));
    check("carry",  64'(carry_out), 64'(got.c));
    check("zero",   64'(zero_out), 64'(got.z));
    check("err",    64'(err), 64'(got.e));
    prev_res = got.res;
    prev_c   = got.c;
    prev_z   = got.z;
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("ready_back", 64'(ready), 64'd1);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
`ifdef SEQ_ABORT_EN
    abort    = 1'b0;
`endif
    cmd      = '0;
    len      = '0;
    op_a     = '0;
    op_b     = '0;
    prev_res = '0;
    prev_c   = 1'b0;
    prev_z   = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  64'(ready), 64'd1);
    check("rst_done",   64'(done), 64'd0);
    check("rst_err",    64'(err), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_carry",  64'(carry_out), 64'd0);
    check("rst_zero",   64'(zero_out), 64'd0);
    check("rst_aluop",  64'(alu_op), 64'(CLR));
    reset_n = 1'b1;

    run_op(3'd0, 4, 32'h00FF_FFFF, 32'h0000_0001, 1'b0);
    check("madd_vec", 64'(result), 64'h0100_0000);
    run_op(3'd1, 2, 32'h0000_0100, 32'h0000_0001, 1'b0);
    check("msub_vec1", 64'(result), 64'h0000_00FF);
    check("msub_c1", 64'(carry_out), 64'd1);
    run_op(3'd1, 2, 32'h0000_0000, 32'h0000_0001, 1'b0);
    check("msub_vec2", 64'(result), 64'h0000_FFFF);
    check("msub_c2", 64'(carry_out), 64'd0);
    run_op(3'd2, 3, 32'h0080_0001, 32'h0, 1'b0);
    check("mlsh_vec", 64'(result), 64'h0000_0002);
    run_op(3'd3, 3, 32'h0000_0101, 32'h0, 1'b0);
    check("mrsh_vec", 64'(result), 64'h0000_0080);
    run_op(3'd4, 4, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    check("mxor_zero", 64'(zero_out), 64'd1);

    run_op(3'd0, 0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    run_op(3'd7, 2, 32'h1234_5678, 32'h1111_1111, 1'b0);
    run_op(3'd0, 5, 32'h1234_5678, 32'h1111_1111, 1'b0);

    run_op(3'd0, 4, 32'h89AB_CDEF, 32'h7654_3211, 1'b1);
    run_op(3'd5, 1, 32'hFFFF_FFF0, 32'h0000_003C, 1'b0);
    run_op(3'd6, 3, 32'hFF00_0F00, 32'h0000_00F0, 1'b0);
    run_op(3'd3, 4, 32'h8000_0000, 32'h0, 1'b1);

    for (int i = 0; i < 10; i++)
      run_op(3'($urandom_range(0, 6)), $urandom_range(1, 4), $urandom, $urandom, 1'b0);

    // Reset mid-op
    @(negedge clk);
    start = 1'b1;
    cmd   = 3'd0;
    len   = LW'(4);
    op_a  = 32'h0102_0304;
    op_b  = 32'h0506_0708;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("midrst_ready",  64'(ready), 64'd1);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_done",   64'(done), 64'd0);
    prev_res = '0;
    prev_c   = 1'b0;
    prev_z   = 1'b0;

`ifdef SEQ_ABORT_EN
    @(negedge clk);
    start = 1'b1;
    cmd   = 3'd0;
    len   = LW'(4);
    op_a  = 32'h1111_1111;
    op_b  = 32'h2222_2222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ready",  64'(ready), 64'd1);
    check("abort_result", 64'(result), 64'd0);
    for (int k = 0; k < 5; k++) begin
      check("abort_nodone", 64'(done), 64'd0);
      @(negedge clk);
    end
    prev_res = '0;
`endif

    run_op(3'd0, 2, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
